// File: rtl/alu_pkg.sv
// Shared opcode values and sequencer state encoding for the ALU subsystem.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_LDAI = 4'h3;
  localparam logic [3:0] OP_LDBI = 4'h4;
  localparam logic [3:0] OP_LDAM = 4'h5;
  localparam logic [3:0] OP_LDBM = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_STR  = 4'h9;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StRwait,
    StHalted
  } state_e;

endpackage

// File: rtl/inst_decode.sv
// Combinational opcode decoder: maps an opcode to its ALU command and control flags.
module inst_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_inst,
  output logic       uses_ram_rd,
  output logic       uses_ram_wr,
  output logic       is_jmp,
  output logic       is_halt
);

  // Opcodes A-F fall into the default and behave as NOP.
  always_comb begin
    alu_inst    = 4'h0;
    uses_ram_rd = 1'b0;
    uses_ram_wr = 1'b0;
    is_jmp      = 1'b0;
    is_halt     = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_HALT: is_halt = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
      OP_LDAI, OP_LDBI, OP_ADD, OP_SUB: alu_inst = op;
      OP_LDAM, OP_LDBM: begin
        alu_inst    = op;
        uses_ram_rd = 1'b1;
      end
      OP_STR:  uses_ram_wr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_sequencer.sv
// Program sequencer: fetches instruction words over req/ack, decodes them and
// issues single-cycle ALU commands and RAM read/write strobes.
module inst_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            prog_req,
  output logic [PC_W-1:0] prog_addr,
  input  logic            prog_ack,
  input  logic [11:0]     prog_data,
  output logic [7:0]      ram_addr,
  output logic            ram_re,
  output logic            ram_we,
  output logic [3:0]      alu_inst,
  output logic [7:0]      alu_data,
  input  logic [7:0]      alu_rtn,
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  // RAM_LAT is limited to 1..3, so a 2-bit counter suffices.
  localparam logic [1:0] LastCnt = 2'(RAM_LAT);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [11:0]     ir_q, ir_d;
  logic [1:0]      cnt_q, cnt_d;

  logic [3:0] op;
  logic [7:0] arg;
  logic [3:0] dec_inst;
  logic       dec_rd, dec_wr, dec_jmp, dec_halt;
  logic       rwait_last;

  assign op         = ir_q[11:8];
  assign arg        = ir_q[7:0];
  assign rwait_last = (cnt_q == LastCnt);

  inst_decode u_decode (
    .op          (op),
    .alu_inst    (dec_inst),
    .uses_ram_rd (dec_rd),
    .uses_ram_wr (dec_wr),
    .is_jmp      (dec_jmp),
    .is_halt     (dec_halt)
  );

  // State, program counter, instruction register and RAM latency counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or HALTED.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (prog_ack) begin
          ir_d    = prog_data;
          state_d = StExec;
        end
      end
      StExec: begin
        if (dec_halt) begin
          state_d = StHalted;
        end else if (dec_jmp) begin
          pc_d    = PC_W'(arg);
          state_d = StFetch;
        end else if (dec_rd) begin
          cnt_d   = 2'd1;
          state_d = StRwait;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = StFetch;
        end
      end
      StRwait: begin
        if (rwait_last) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state and latched instruction word.
  always_comb begin
    prog_req  = (state_q == StFetch);
    prog_addr = pc_q;
    pc        = pc_q;
    ram_addr  = arg;
    alu_data  = arg;
    ram_re    = (state_q == StExec) && dec_rd;
    ram_we    = (state_q == StExec) && dec_wr;
    alu_inst  = 4'h0;
    if ((state_q == StExec) && !dec_rd) begin
      alu_inst = dec_inst;
    end else if ((state_q == StRwait) && rwait_last) begin
      alu_inst = dec_inst;
    end
    busy   = (state_q != StIdle) && (state_q != StHalted);
    halted = (state_q == StHalted);
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: strobe scoreboard plus directed timing checks.
module tb_inst_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        prog_req;
  logic [7:0]  prog_addr;
  logic        prog_ack;
  logic [11:0] prog_data;
  logic [7:0]  ram_addr;
  logic        ram_re;
  logic        ram_we;
  logic [3:0]  alu_inst;
  logic [7:0]  alu_data;
  logic [7:0]  alu_rtn;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;

  // Narrow instance used for the program-counter wrap test.
  logic        start4;
  logic        prog_req4;
  logic [3:0]  prog_addr4;
  logic [7:0]  ram_addr4;
  logic        ram_re4;
  logic        ram_we4;
  logic [3:0]  alu_inst4;
  logic [7:0]  alu_data4;
  logic        busy4;
  logic        halted4;
  logic [3:0]  pc4;

  int nvec = 0;
  int nerr = 0;

  logic [11:0] rom [256];
  int          ack_dly = 0;
  int          wait_cnt = 0;
  logic        ack_model = 1'b0;
  logic        ack_force = 1'b0;
  logic [7:0]  reg_a = '0;
  logic [7:0]  reg_b = '0;
  logic [29:0] exp_q [$];

  assign prog_ack = ack_model | ack_force;

  inst_sequencer #(.PC_W(8), .RAM_LAT(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .prog_req  (prog_req),
    .prog_addr (prog_addr),
    .prog_ack  (prog_ack),
    .prog_data (prog_data),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .alu_inst  (alu_inst),
    .alu_data  (alu_data),
    .alu_rtn   (alu_rtn),
    .busy      (busy),
    .halted    (halted),
    .pc        (pc)
  );

  inst_sequencer #(.PC_W(4), .RAM_LAT(1)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .start     (start4),
    .prog_req  (prog_req4),
    .prog_addr (prog_addr4),
    .prog_ack  (prog_req4),
    .prog_data (12'h000),
    .ram_addr  (ram_addr4),
    .ram_re    (ram_re4),
    .ram_we    (ram_we4),
    .alu_inst  (alu_inst4),
    .alu_data  (alu_data4),
    .alu_rtn   (8'h00),
    .busy      (busy4),
    .halted    (halted4),
    .pc        (pc4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] ev(input logic [3:0] inst, input logic [7:0] data,
                                     input logic re, input logic we,
                                     input logic [7:0] addr, input logic [7:0] wd);
    return {inst, data, re, we, addr, wd};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Program ROM: answers a request after ack_dly waiting cycles.
  always @(negedge clock) begin
    if (prog_req) begin
      if (wait_cnt >= ack_dly) begin
        ack_model <= 1'b1;
        prog_data <= rom[prog_addr];
        wait_cnt  <= 0;
      end else begin
        ack_model <= 1'b0;
        wait_cnt  <= wait_cnt + 1;
      end
    end else begin
      ack_model <= 1'b0;
      wait_cnt  <= 0;
    end
  end

  // Minimal ALU: registers and a result register updated on each command.
  always @(posedge clock) begin
    case (alu_inst)
      4'h3: reg_a <= alu_data;
      4'h4: reg_b <= alu_data;
      4'h7: alu_rtn <= reg_a + reg_b;
      4'h8: alu_rtn <= reg_a - reg_b;
      default: ;
    endcase
  end

  // Strobe monitor: every cycle with a strobe must match the next scoreboard entry.
  always @(negedge clock) begin
    logic [29:0] obs;
    if (alu_inst != 4'h0 || ram_re || ram_we) begin
      obs = ev(alu_inst, (alu_inst == 4'h3 || alu_inst == 4'h4) ? alu_data : 8'h00,
               ram_re, ram_we, (ram_re || ram_we) ? ram_addr : 8'h00,
               ram_we ? alu_rtn : 8'h00);
      check("re_we_exclusive", 32'(ram_re & ram_we), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(obs), 32'd0);
      end else begin
        check("strobe", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pc;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    alu_rtn = 8'h00;
    reset   = 1'b0;
    start   = 1'b0;
    start4  = 1'b0;

    // Reset state, with start ignored while reset is held.
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("rst_outputs", {prog_req, ram_re, ram_we, busy, halted, alu_inst, alu_data,
                          ram_addr, pc}, 32'd0);
    check("rst_pc4", {busy4, pc4}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_rst", {busy, halted, prog_req}, 32'd0);

    // 1: LDAI 5, LDBI 3, ADD, STR 0x10, HALT with zero-wait ack.
    rom[0] = 12'h305;
    rom[1] = 12'h403;
    rom[2] = 12'h700;
    rom[3] = 12'h910;
    rom[4] = 12'h100;
    exp_q.push_back(ev(4'h3, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00));
    exp_q.push_back(ev(4'h4, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00));
    exp_q.push_back(ev(4'h7, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
    exp_q.push_back(ev(4'h0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h08));
    pulse_start();
    check("t1_busy", {busy, halted, prog_req}, 32'b101);
    repeat (9) @(negedge clock);
    check("t1_not_yet_halted", {busy, halted}, 32'b10);
    @(negedge clock);
    check("t1_halted", {busy, halted}, 32'b01);
    check("t1_pc", 32'(pc), 32'd4);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: LDAM 0x20 with RAM_LAT=2.
    rom[0] = 12'h520;
    rom[1] = 12'h100;
    exp_q.push_back(ev(4'h0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00));
    exp_q.push_back(ev(4'h5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
    pulse_start();
    @(negedge clock);
    check("t2_re", {ram_re, alu_inst}, {27'd0, 1'b1, 4'h0});
    @(negedge clock);
    check("t2_wait1", {ram_re, alu_inst}, 32'd0);
    @(negedge clock);
    check("t2_load", {ram_re, alu_inst}, 32'h5);
    @(negedge clock);
    check("t2_after", {alu_inst, prog_req}, 32'h1);
    check("t2_pc", 32'(pc), 32'd1);
    repeat (2) @(negedge clock);
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset during RWAIT aborts; start afterwards refetches from pc=0.
    exp_q.push_back(ev(4'h0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00));
    pulse_start();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("t5_abort", {ram_re, ram_we, alu_inst, busy, prog_req, pc}, 32'd0);
    @(negedge clock);
    check("t5_idle", {busy, halted, alu_inst, pc}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    exp_q.push_back(ev(4'h0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00));
    exp_q.push_back(ev(4'h5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00));
    pulse_start();
    check("t5_refetch", {prog_req, prog_addr}, {23'd0, 1'b1, 8'h00});
    repeat (6) @(negedge clock);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: opcode 0xC acts as NOP; start while busy and ack outside FETCH are ignored.
    rom[0] = 12'hC00;
    rom[1] = 12'h100;
    pulse_start();
    @(negedge clock);
    start = 1'b1;
    check("t6_exec_pc", 32'(pc), 32'd0);
    @(negedge clock);
    start = 1'b0;
    check("t6_pc_adv", {prog_req, pc}, {23'd0, 1'b1, 8'd1});
    repeat (2) @(negedge clock);
    check("t6_halted", {halted, pc}, {23'd0, 1'b1, 8'd1});
    ack_force = 1'b1;
    repeat (3) @(negedge clock);
    check("t6_ack_ignored", {busy, halted, pc}, {22'd0, 2'b01, 8'd1});
    ack_force = 1'b0;
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: JMP 0 loop with ack delayed 3 cycles.
    rom[0] = 12'h200;
    ack_dly = 3;
    pulse_start();
    check("t3_req0", 32'(prog_req), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("t3_req%0d", i), 32'(prog_req), 32'd1);
    end
    @(negedge clock);
    check("t3_exec", {prog_req, busy, pc}, {23'd0, 1'b0, 8'h00} | 32'h100);
    @(negedge clock);
    check("t3_refetch", {prog_req, pc}, {23'd0, 1'b1, 8'h00});
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t3_busy", 32'(busy), 32'd1);
    end
    rom[0] = 12'h100;
    ack_dly = 0;
    for (int i = 0; i < 20 && !halted; i++) @(negedge clock);
    check("t3_halted", {halted, pc}, {23'd0, 1'b1, 8'h00});

    // 4: PC_W=4 instance running NOPs wraps 15 -> 0 and keeps going.
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    exp_pc = 0;
    for (int i = 0; i < 40; i++) begin
      if (prog_req4) begin
        check("t4_pc", 32'(pc4), 32'(exp_pc));
        exp_pc = (exp_pc + 1) % 16;
      end else begin
        check("t4_no_strobe", {alu_inst4, ram_re4, ram_we4}, 32'd0);
      end
      @(negedge clock);
    end
    check("t4_busy", {busy4, halted4}, 32'b10);
    check("t4_wrapped", 32'(exp_pc), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
